// File: rtl/microgreen_pkg.sv
// Shared definitions for the microgreen sensor front end and classifier.
// Holds the frame geometry, the default checksum key, the receiver FSM
// state encoding, and the ui_in field slice positions that the classifier
// also uses.
package microgreen_pkg;

    localparam int unsigned FRAME_BITS        = 24;
    localparam logic [7:0]  CHECK_KEY_DEFAULT = 8'hA5;

    // Field positions inside the classifier ui_in byte {color, texture}
    localparam int unsigned COLOR_MSB   = 7;
    localparam int unsigned COLOR_LSB   = 4;
    localparam int unsigned TEXTURE_MSB = 3;
    localparam int unsigned TEXTURE_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_PUBLISH
    } state_t;

    // Expected trailer byte for a frame carrying b0/b1
    function automatic logic [7:0] frame_checksum(input logic [7:0] b0,
                                                  input logic [7:0] b1,
                                                  input logic [7:0] key);
        return b0 ^ b1 ^ key;
    endfunction

endpackage

// File: rtl/microgreen_sync_edge.sv
// Multi-flop synchronizer for an asynchronous single-bit input, followed by
// an edge detector working on the last two synchronized samples.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset (chain loads RESET_VALUE)
//   din   - asynchronous input
//   rise  - one-cycle pulse on a synchronized 0->1 transition
//   fall  - one-cycle pulse on a synchronized 1->0 transition
module microgreen_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RESET_VALUE}};
            prev  <= RESET_VALUE;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    always_comb begin
        rise = chain[SYNC_STAGES-1] & ~prev;
        fall = ~chain[SYNC_STAGES-1] & prev;
    end

endmodule

// File: rtl/microgreen_feature_rx.sv
// Serial feature-frame receiver feeding the microgreen BNN classifier.
// Receives 24-bit frames {B0=color/texture, B1=height, B2=checksum} from the
// sensor MCU, validates length and checksum, and publishes the feature bytes
// through a valid/ack handshake. Keeps sticky error flags and a saturating
// rejected-frame counter.
// Ports:
//   clk, rst               - system clock, synchronous active-high reset
//   sclk_in, sdata_in      - async serial clock/data (data sampled on sclk rise)
//   cs_n_in                - async active-low frame enable
//   feat_ui, feat_height   - published feature words (ui_in / uio_in format)
//   feat_valid, feat_ack   - publish handshake
//   frame_err, chk_err     - sticky length/timeout and checksum errors
//   overrun                - sticky: good frame dropped while slot occupied
//   err_count              - saturating count of rejected frames
//   err_clr                - clears sticky flags and err_count
module microgreen_feature_rx
    import microgreen_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter logic [7:0]  CHECK_KEY      = CHECK_KEY_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_in,
    input  logic       sdata_in,
    input  logic       cs_n_in,
    output logic [7:0] feat_ui,
    output logic [7:0] feat_height,
    output logic       feat_valid,
    input  logic       feat_ack,
    output logic       frame_err,
    output logic       chk_err,
    output logic       overrun,
    output logic [7:0] err_count,
    input  logic       err_clr
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0] BIT_CNT_MAX = 5'd25;

    // ---------------- input synchronization ----------------
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic sdata_s;

    microgreen_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (1'b0)
    ) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk_in),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // cs_n idles high, so its chain resets high to avoid a phantom edge
    microgreen_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (cs_n_in),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // Same depth as the sclk chain so data lines up with the detected edge
    always_ff @(posedge clk) begin
        if (rst) sdata_sync <= '0;
        else     sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata_in};
    end
    assign sdata_s = sdata_sync[SYNC_STAGES-1];

    // ---------------- FSM ----------------
    state_t state, state_next;

    logic [FRAME_BITS-1:0] shift_reg;
    logic [4:0]            bit_cnt;
    logic [TO_W-1:0]       to_cnt;

    logic sclk_edge, timeout_hit;
    logic len_bad, sum_bad, slot_busy, accept;
    logic clear_frame, shift_en;
    logic set_frame_err, set_chk_err, set_overrun, err_inc, load_features;

    // Any sclk transition proves the master is alive
    assign sclk_edge   = sclk_rise | sclk_fall;
    assign timeout_hit = (state == ST_SHIFT) && !sclk_edge && (to_cnt == TO_LIMIT);

    assign len_bad   = (bit_cnt != 5'(FRAME_BITS));
    assign sum_bad   = (shift_reg[7:0] != frame_checksum(shift_reg[23:16], shift_reg[15:8], CHECK_KEY));
    assign slot_busy = feat_valid & ~feat_ack;
    assign accept    = ~len_bad & ~sum_bad & ~slot_busy;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (cs_fall) state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (timeout_hit)  state_next = ST_IDLE;
                else if (cs_rise) state_next = ST_CHECK;
            end
            ST_CHECK:   state_next = accept ? ST_PUBLISH : ST_IDLE;
            ST_PUBLISH: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        clear_frame   = 1'b0;
        shift_en      = 1'b0;
        set_frame_err = 1'b0;
        set_chk_err   = 1'b0;
        set_overrun   = 1'b0;
        load_features = 1'b0;
        unique case (state)
            ST_IDLE:  clear_frame = cs_fall;
            ST_SHIFT: begin
                shift_en      = sclk_rise;
                set_frame_err = timeout_hit;
            end
            ST_CHECK: begin
                set_frame_err = len_bad;
                set_chk_err   = ~len_bad & sum_bad;
                set_overrun   = ~len_bad & ~sum_bad & slot_busy;
                // Registered on the way into PUBLISH so the words are
                // visible during the PUBLISH cycle itself
                load_features = accept;
            end
            default: ;
        endcase
        err_inc = set_frame_err | set_chk_err | set_overrun;
    end

    // ---------------- frame datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
        end else begin
            if (clear_frame) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], sdata_s};
                if (bit_cnt != BIT_CNT_MAX) bit_cnt <= bit_cnt + 5'd1;
            end

            if (clear_frame || (state == ST_SHIFT && sclk_edge)) to_cnt <= '0;
            else if (state == ST_SHIFT)                         to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // ---------------- publish handshake ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            feat_ui     <= '0;
            feat_height <= '0;
            feat_valid  <= 1'b0;
        end else if (load_features) begin
            feat_ui[COLOR_MSB:COLOR_LSB]     <= shift_reg[16+COLOR_MSB:16+COLOR_LSB];
            feat_ui[TEXTURE_MSB:TEXTURE_LSB] <= shift_reg[16+TEXTURE_MSB:16+TEXTURE_LSB];
            feat_height                      <= shift_reg[15:8];
            feat_valid                       <= 1'b1;
        end else if (feat_valid && feat_ack) begin
            feat_valid <= 1'b0;
        end
    end

    // ---------------- error statistics ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            chk_err   <= 1'b0;
            overrun   <= 1'b0;
            err_count <= '0;
        end else begin
            // A new error in the clear cycle survives the clear
            frame_err <= set_frame_err | (frame_err & ~err_clr);
            chk_err   <= set_chk_err   | (chk_err   & ~err_clr);
            overrun   <= set_overrun   | (overrun   & ~err_clr);
            if (err_clr)
                err_count <= err_inc ? 8'd1 : 8'd0;
            else if (err_inc && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_microgreen_feature_rx.sv
// Directed self-checking bench for microgreen_feature_rx.
module tb_microgreen_feature_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk_in, sdata_in, cs_n_in;
    logic [7:0] feat_ui, feat_height, err_count;
    logic       feat_valid, feat_ack, frame_err, chk_err, overrun, err_clr;

    int tests_run    = 0;
    int tests_failed = 0;
    int hp           = 4;   // sclk half period in clk cycles

    microgreen_feature_rx #(
        .SYNC_STAGES    (2),
        .CHECK_KEY      (8'hA5),
        .TIMEOUT_CYCLES (4096)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk_in     (sclk_in),
        .sdata_in    (sdata_in),
        .cs_n_in     (cs_n_in),
        .feat_ui     (feat_ui),
        .feat_height (feat_height),
        .feat_valid  (feat_valid),
        .feat_ack    (feat_ack),
        .frame_err   (frame_err),
        .chk_err     (chk_err),
        .overrun     (overrun),
        .err_count   (err_count),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        cs_n_in = 1'b0;
        repeat (2 * hp) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sdata_in = data[23 - i];
            repeat (hp) @(negedge clk);
            sclk_in = 1'b1;
            repeat (hp) @(negedge clk);
            sclk_in = 1'b0;
        end
    endtask

    // Raises cs_n; the CHECK cycle is the third clk after the raise.
    // ack/clr are driven only during that cycle. vb/va are feat_valid in
    // the CHECK cycle and in the following (PUBLISH) cycle.
    task automatic end_frame(input logic ack, input logic clr, output logic vb, output logic va);
        repeat (hp) @(negedge clk);
        cs_n_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vb       = feat_valid;
        feat_ack = ack;
        err_clr  = clr;
        @(posedge clk);
        @(negedge clk);
        va       = feat_valid;
        feat_ack = 1'b0;
        err_clr  = 1'b0;
        repeat (8 * hp) @(negedge clk);
    endtask

    task automatic frame(input logic [23:0] data, input int nbits, input logic ack, input logic clr);
        logic vb, va;
        start_frame();
        send_bits(data, nbits);
        end_frame(ack, clr, vb, va);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        feat_ack = 1'b1;
        @(negedge clk);
        feat_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic vb, va;
        bit   seen;

        rst = 1'b1; sclk_in = 1'b0; sdata_in = 1'b0; cs_n_in = 1'b1;
        feat_ack = 1'b0; err_clr = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_ui", feat_ui, 8'h00);
        check("rst_height", feat_height, 8'h00);
        check("rst_valid", {7'd0, feat_valid}, 8'h00);
        check("rst_flags", {5'd0, frame_err, chk_err, overrun}, 8'h00);
        check("rst_count", err_count, 8'h00);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Good frame: 0xC9 ^ 0x90 ^ 0xA5 = 0xFC
        start_frame();
        send_bits(24'hC990FC, 24);
        end_frame(1'b0, 1'b0, vb, va);
        check("good_valid_check_cycle", {7'd0, vb}, 8'h00);
        check("good_valid_publish_cycle", {7'd0, va}, 8'h01);
        check("good_ui", feat_ui, 8'hC9);
        check("good_height", feat_height, 8'h90);
        check("good_flags", {5'd0, frame_err, chk_err, overrun}, 8'h00);
        check("good_count", err_count, 8'h00);
        pulse_ack();
        check("ack_valid", {7'd0, feat_valid}, 8'h00);
        check("ack_ui_retained", feat_ui, 8'hC9);
        pulse_ack();
        check("idle_ack_valid", {7'd0, feat_valid}, 8'h00);

        // Bad checksum
        frame(24'hC990FD, 24, 1'b0, 1'b0);
        check("badsum_chk_err", {7'd0, chk_err}, 8'h01);
        check("badsum_count", err_count, 8'h01);
        check("badsum_valid", {7'd0, feat_valid}, 8'h00);
        check("badsum_frame_err", {7'd0, frame_err}, 8'h00);
        pulse_clr();
        check("clr_flags", {5'd0, frame_err, chk_err, overrun}, 8'h00);
        check("clr_count", err_count, 8'h00);

        // Short frame (16 bits)
        frame(24'hC990FC, 16, 1'b0, 1'b0);
        check("short_frame_err", {7'd0, frame_err}, 8'h01);
        check("short_count", err_count, 8'h01);
        check("short_chk_err", {7'd0, chk_err}, 8'h00);
        pulse_clr();

        // Long frame (25 bits)
        frame(24'hC990FC, 24, 1'b0, 1'b0);
        check("long_ok_first", {7'd0, feat_valid}, 8'h01);
        pulse_ack();
        start_frame();
        send_bits(24'hC990FC, 24);
        send_bits(24'h800000, 1);
        end_frame(1'b0, 1'b0, vb, va);
        check("long_frame_err", {7'd0, frame_err}, 8'h01);
        check("long_valid", {7'd0, feat_valid}, 8'h00);
        pulse_clr();

        // Timeout: cs_n low with no sclk
        @(negedge clk);
        cs_n_in = 1'b0;
        repeat (4000) @(negedge clk);
        check("timeout_early", {7'd0, frame_err}, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (frame_err) seen = 1'b1;
        end
        check("timeout_seen", {7'd0, seen}, 8'h01);
        check("timeout_count", err_count, 8'h01);
        repeat (4) @(negedge clk);
        cs_n_in = 1'b1;
        repeat (8 * hp) @(negedge clk);
        pulse_clr();
        // Receiver must be back in IDLE and accept a fresh frame
        frame(24'hC990FC, 24, 1'b0, 1'b0);
        check("post_timeout_valid", {7'd0, feat_valid}, 8'h01);
        check("post_timeout_flags", {5'd0, frame_err, chk_err, overrun}, 8'h00);

        // Overrun: slot holds C9/90, 0x30 ^ 0x41 ^ 0xA5 = 0xD4
        frame(24'h3041D4, 24, 1'b0, 1'b0);
        check("ovr_flag", {7'd0, overrun}, 8'h01);
        check("ovr_count", err_count, 8'h01);
        check("ovr_ui_kept", feat_ui, 8'hC9);
        check("ovr_height_kept", feat_height, 8'h90);
        check("ovr_valid_kept", {7'd0, feat_valid}, 8'h01);
        pulse_clr();
        // Ack in the CHECK cycle frees the slot
        frame(24'h3041D4, 24, 1'b1, 1'b0);
        check("ackchk_ui", feat_ui, 8'h30);
        check("ackchk_height", feat_height, 8'h41);
        check("ackchk_valid", {7'd0, feat_valid}, 8'h01);
        check("ackchk_overrun", {7'd0, overrun}, 8'h00);
        check("ackchk_count", err_count, 8'h00);
        pulse_ack();

        // err_clr coinciding with a new error: new error wins
        frame(24'hC990FD, 24, 1'b0, 1'b0);
        check("pre_clr_count", err_count, 8'h01);
        frame(24'h3041D5, 24, 1'b0, 1'b1);
        check("clr_race_count", err_count, 8'h01);
        check("clr_race_chk_err", {7'd0, chk_err}, 8'h01);

        // Make the slot non-zero before the mid-frame reset
        frame(24'hC990FC, 24, 1'b0, 1'b0);
        start_frame();
        send_bits(24'hC990FC, 10);
        @(negedge clk);
        rst = 1'b1; cs_n_in = 1'b1; sclk_in = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_ui", feat_ui, 8'h00);
        check("midrst_height", feat_height, 8'h00);
        check("midrst_valid", {7'd0, feat_valid}, 8'h00);
        check("midrst_flags", {5'd0, frame_err, chk_err, overrun}, 8'h00);
        check("midrst_count", err_count, 8'h00);
        rst = 1'b0;
        repeat (8 * hp) @(negedge clk);
        check("midrst_quiet_flags", {5'd0, frame_err, chk_err, overrun}, 8'h00);
        frame(24'h3041D4, 24, 1'b0, 1'b0);
        check("midrst_pub_ui", feat_ui, 8'h30);
        check("midrst_pub_height", feat_height, 8'h41);
        check("midrst_pub_valid", {7'd0, feat_valid}, 8'h01);
        check("midrst_pub_flags", {5'd0, frame_err, chk_err, overrun}, 8'h00);
        pulse_ack();

        // Saturation with a faster (clk/6) serial clock
        hp = 3;
        for (int i = 0; i < 10; i++) frame(24'hC990FD, 24, 1'b0, 1'b0);
        check("sat_count_10", err_count, 8'h0A);
        for (int i = 0; i < 250; i++) frame(24'hC990FD, 24, 1'b0, 1'b0);
        check("sat_count_260", err_count, 8'hFF);
        check("sat_chk_err", {7'd0, chk_err}, 8'h01);
        check("sat_valid", {7'd0, feat_valid}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
